// File: rtl/tdm_demux_4_pkg.sv
// Shared TDM definitions: frame state encoding and slot indices, common to the mux and demux ends.
package tdm_demux_4_pkg;
  localparam int NUM_SLOTS = 4;

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [1:0] SLOT0 = 2'd0;
  localparam logic [1:0] SLOT1 = 2'd1;
  localparam logic [1:0] SLOT3 = 2'd3;
endpackage

// File: rtl/tdm_slot_ctr.sv
// 2-bit TDM slot counter: clear on loss of lock, load to slot 1 on a sync capture, else advance per accepted sample.
module tdm_slot_ctr
  import tdm_demux_4_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       load,
  input  logic       inc,
  output logic [1:0] slot
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot <= SLOT0;
    end else if (clr) begin
      slot <= SLOT0;
    end else if (load) begin
      slot <= SLOT1;
    end else if (inc) begin
      slot <= slot + 2'd1;
    end
  end

endmodule

// File: rtl/tdm_demux_4.sv
// 4-channel TDM demultiplexer: aligns on slot-0 sync, steers samples into channel registers with
// per-channel/per-frame strobes. One-cycle latency; idle cycles (din_valid=0) are gaps and keep lock.
module tdm_demux_4
  import tdm_demux_4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic [3:0]       ch_valid,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  logic [0:0]       state;
  logic [1:0]       slot;
  logic [WIDTH-1:0] ch_q [NUM_SLOTS];
  logic             accept_sync;
  logic             accept_data;
  logic             miss_sync;

  assign accept_sync = din_valid & sync;
  assign accept_data = din_valid & ~sync & (state == LOCKED) & (slot != SLOT0);
  assign miss_sync   = din_valid & ~sync & (state == LOCKED) & (slot == SLOT0);

  tdm_slot_ctr u_slot_ctr (
    .clock (clock),
    .reset (reset),
    .clr   (miss_sync),
    .load  (accept_sync),
    .inc   (accept_data),
    .slot  (slot)
  );

  // Slots 1..3 can only be reached in order from a sync capture, so reaching slot 3 implies a coherent frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      ch_valid    <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) ch_q[i] <= '0;
    end else begin
      ch_valid    <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (accept_sync) begin
        ch_q[SLOT0] <= din;
        ch_valid    <= 4'b0001;
        sync_err    <= (state == LOCKED) && (slot != SLOT0);
        state       <= LOCKED;
      end else if (accept_data) begin
        ch_q[slot]  <= din;
        ch_valid    <= 4'b0001 << slot;
        frame_valid <= (slot == SLOT3);
      end else if (miss_sync) begin
        sync_err <= 1'b1;
        state    <= HUNT;
      end
    end
  end

  assign locked = (state == LOCKED);
  assign ch0    = ch_q[0];
  assign ch1    = ch_q[1];
  assign ch2    = ch_q[2];
  assign ch3    = ch_q[3];

endmodule

// File: tb/tb_tdm_demux_4.sv
// Directed and random bench for tdm_demux_4 against a frame-level reference model.
module tb_tdm_demux_4;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       sync = 1'b0;
  logic [7:0] ch0, ch1, ch2, ch3;
  logic [3:0] ch_valid;
  logic       frame_valid, locked, sync_err;

  int tests = 0;
  int fails = 0;

  // Reference model: aligned flag, next expected slot, slots collected in current frame.
  logic [7:0] m_ch [4];
  logic [3:0] m_cv;
  logic       m_fv, m_err, m_locked;
  int         m_slot, m_cnt;

  tdm_demux_4 #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch_valid(ch_valid),
    .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_ch[i] = '0;
    m_cv = '0; m_fv = 0; m_err = 0; m_locked = 0; m_slot = 0; m_cnt = 0;
  endtask

  task automatic model_update(input logic v, input logic s, input logic [7:0] d);
    m_cv = '0; m_fv = 0; m_err = 0;
    if (v) begin
      if (s) begin
        m_err = m_locked && (m_slot != 0);
        m_ch[0] = d; m_cv = 4'b0001;
        m_locked = 1; m_slot = 1; m_cnt = 1;
      end else if (m_locked) begin
        if (m_slot == 0) begin
          m_err = 1; m_locked = 0; m_cnt = 0;
        end else begin
          m_ch[m_slot] = d;
          m_cv[m_slot] = 1'b1;
          m_fv = (m_slot == 3) && (m_cnt == 3);
          m_cnt = m_cnt + 1;
          m_slot = (m_slot + 1) % 4;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ch0"}, 32'(ch0), 32'(m_ch[0]));
    chk({tag, ".ch1"}, 32'(ch1), 32'(m_ch[1]));
    chk({tag, ".ch2"}, 32'(ch2), 32'(m_ch[2]));
    chk({tag, ".ch3"}, 32'(ch3), 32'(m_ch[3]));
    chk({tag, ".ch_valid"}, 32'(ch_valid), 32'(m_cv));
    chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
    chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
    chk({tag, ".sync_err"}, 32'(sync_err), 32'(m_err));
  endtask

  task automatic step(input string tag, input logic v, input logic s, input logic [7:0] d);
    @(negedge clock);
    din_valid = v; sync = s; din = d;
    @(posedge clock);
    #1;
    model_update(v, s, d);
    check_all(tag);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step("gap", 1'b0, 1'b0, 8'hXX & 8'h00);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    din_valid = 0; sync = 0;
    reset = 1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clock);
    reset = 0;
  endtask

  initial begin
    model_reset();
    #1;
    check_all("por");
    @(negedge clock);
    reset = 0;

    // Reset mid-frame, asserted between edges
    step("rst.s0", 1, 1, 8'hA1);
    step("rst.s1", 1, 0, 8'hB2);
    @(posedge clock);
    #2;
    reset = 1;
    #1;
    model_reset();
    check_all("rst.async");
    @(negedge clock);
    reset = 0;
    step("rst.drop", 1, 0, 8'hC3);

    // Clean frame
    step("clean.s0", 1, 1, 8'hA1);
    step("clean.s1", 1, 0, 8'hB2);
    step("clean.s2", 1, 0, 8'hC3);
    step("clean.s3", 1, 0, 8'hD4);
    step("clean.idle", 0, 0, 8'h00);

    // Gapped frame
    step("gap.s0", 1, 1, 8'hA1); gap(3);
    step("gap.s1", 1, 0, 8'hB2); gap(3);
    step("gap.s2", 1, 0, 8'hC3); gap(3);
    step("gap.s3", 1, 0, 8'hD4); gap(3);

    // Missing sync, then relock
    step("miss.s", 1, 0, 8'h55);
    step("miss.relock", 1, 1, 8'h11);
    step("miss.s1", 1, 0, 8'h22);
    step("miss.s2", 1, 0, 8'h33);
    step("miss.s3", 1, 0, 8'h44);

    // Early sync aborts frame
    step("early.s0", 1, 1, 8'hA1);
    step("early.s1", 1, 0, 8'hB2);
    step("early.sync", 1, 1, 8'hEE);
    step("early.s1b", 1, 0, 8'h12);
    step("early.s2b", 1, 0, 8'h13);
    step("early.s3b", 1, 0, 8'h14);

    // Hunt filtering from reset
    do_reset("hunt.rst");
    step("hunt.d1", 1, 0, 8'h01);
    step("hunt.d2", 1, 0, 8'h02);
    step("hunt.s0", 1, 1, 8'h10);
    step("hunt.s1", 1, 0, 8'h20);
    step("hunt.s2", 1, 0, 8'h30);
    step("hunt.s3", 1, 0, 8'h40);

    // Random stream: mostly well-formed framing with occasional sync faults and gaps
    for (int i = 0; i < 600; i++) begin
      logic v, s;
      v = ($urandom_range(0, 3) != 0);
      if (m_locked && m_slot != 0) s = ($urandom_range(0, 15) == 0);
      else s = ($urandom_range(0, 7) != 0);
      step("rand", v, s, 8'($urandom));
      if ($urandom_range(0, 199) == 0) do_reset("rand.rst");
    end

    @(negedge clock);
    din_valid = 0; sync = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
